// File: rtl/regfile_sb_if.sv
// Bus between the issue/writeback stages and the register file:
// write port, two read ports, issue strobe and scoreboard status.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            clr;
    logic            ready;
    logic            we;
    logic [AW-1:0]   a3;
    logic [XLEN-1:0] wd;
    logic [AW-1:0]   a1;
    logic [AW-1:0]   a2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            iss_en;
    logic [AW-1:0]   iss_rd;
    logic            busy1;
    logic            busy2;

    // Pipeline side: drives addresses, data and strobes.
    modport master (
        output clr, we, a3, wd, a1, a2, iss_en, iss_rd,
        input  ready, rd1, rd2, busy1, busy2
    );

    // Register file side.
    modport slave (
        input  clr, we, a3, wd, a1, a2, iss_en, iss_rd,
        output ready, rd1, rd2, busy1, busy2
    );
endinterface

// File: rtl/regfile_sb.sv
// RV32I integer register file: two combinational read ports, one write
// port, optional write-to-read bypass and a pending-write scoreboard.
// Storage is zeroed by a sequential sweep after reset or soft clear so
// the array itself carries no reset and maps onto distributed RAM.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    regfile_sb_if.slave  bus
);

    localparam int            NREGS = 2 ** AW;
    localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);
    localparam bit            BYP   = (BYPASS != 0);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t           state_q;
    logic [AW-1:0]    ptr_q;
    logic             ready_q;
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [XLEN-1:0]  rf_q [NREGS];

    // Qualified strobes: nothing from the pipeline is honoured until the
    // sweep has finished, and x0 is never a write or scoreboard target.
    logic wr_en;
    logic iss_set;
    logic byp1;
    logic byp2;

    assign wr_en   = ready_q & bus.we & (bus.a3 != '0);
    assign iss_set = ready_q & bus.iss_en & (bus.iss_rd != '0);
    assign byp1    = BYP & bus.we & (bus.a3 == bus.a1);
    assign byp2    = BYP & bus.we & (bus.a3 == bus.a2);

    // Sweep/run controller; ready is registered so it is glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            ptr_q   <= AW'(1);
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (bus.clr) begin
                        ptr_q <= AW'(1);
                    end else if (ptr_q == LAST) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + AW'(1);
                    end
                end
                S_RUN: begin
                    if (bus.clr) begin
                        state_q <= S_INIT;
                        ptr_q   <= AW'(1);
                        ready_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Storage: sweep writes zero at ptr, otherwise the writeback port.
    // NOTE: the array has no reset on purpose; the sweep clears it, which
    // keeps it a plain RAM instead of NREGS*XLEN resettable flops.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            rf_q[ptr_q] <= '0;
        end else if (wr_en) begin
            rf_q[bus.a3] <= bus.wd;
        end
    end

    // Scoreboard next state: writeback clears, issue sets (set wins as the
    // newer producer), soft clear wipes everything.
    // NOTE: busy_d gets a full default first and is built up with blocking
    // assignments so later lines override earlier ones without a latch.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[bus.a3] = 1'b0;
        end
        if (iss_set) begin
            busy_d[bus.iss_rd] = 1'b1;
        end
        if (bus.clr) begin
            busy_d = '0;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read ports: x0 is hardwired to zero, same-cycle write is forwarded
    // when bypass is enabled, and everything reads zero until ready.
    assign bus.rd1 = (!ready_q || bus.a1 == '0) ? '0 :
                     byp1                       ? bus.wd :
                                                  rf_q[bus.a1];
    assign bus.rd2 = (!ready_q || bus.a2 == '0) ? '0 :
                     byp2                       ? bus.wd :
                                                  rf_q[bus.a2];

    // A forwarded write resolves the hazard in the same cycle.
    assign bus.busy1 = ready_q & busy_q[bus.a1] & ~byp1;
    assign bus.busy2 = ready_q & busy_q[bus.a2] & ~byp2;

    assign bus.ready = ready_q;

endmodule
